hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU: generates the per-cycle keep/flush/freeze strobes consumed by the IF/ID, ID/EX and EX/MEM pipe registers and the PC write enable. Detects load-use hazards between ID and EX, applies branch-taken flushes resolved in MEM, and freezes the whole pipeline for a fixed multi-cycle data-memory latency via an internal FSM. Sits beside the pipe registers, driving their keep and flush inputs.

## Interface
- MEM_LAT, 2: data-memory wait cycles per access; 0 disables waiting.
- REG_AW, 5: register-address width.
- CNT_W, 16: statistics counter width.

- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- id_rs_i  in  REG_AW  rs of instruction in ID.
- id_rt_i  in  REG_AW  rt of instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- ex_memread_i  in  1  EX instruction is a load.
- ex_rt_i  in  REG_AW  load destination in EX.
- mem_req_i  in  1  MEM instruction accesses data memory.
- branch_taken_i  in  1  branch in MEM resolved taken.
- pc_write_o  out  1  PC update enable.
- if_keep_o  out  1  hold IF/ID.
- if_flush_o  out  1  clear IF/ID.
- id_flush_o  out  1  clear ID/EX (bubble).
- ex_flush_o  out  1  clear EX/MEM.
- freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0.
- flush_cnt_o  out  CNT_W  branch flush events.

## Operation
- FSM states: RUN, WAIT, RELEASE. Reset: RUN, wait counter 0, stat counters 0.
- Outputs are combinational from state and inputs; priority freeze > branch flush > load-use > normal.
- Freeze (freeze_o=1): pc_write_o=0, if_keep_o=1, all flushes 0.
  - RUN with mem_req_i=1 and MEM_LAT>0: freeze; cnt<=MEM_LAT-1; next = RELEASE if MEM_LAT=1, else WAIT.
  - WAIT: freeze; cnt decrements; when cnt=1 next RELEASE.
  - RELEASE: no freeze (pipeline advances the same access); mem_req_i ignored; next RUN.
  - MEM_LAT=0: mem_req_i ignored, FSM stays in RUN.
- Branch flush (not frozen, branch_taken_i=1): pc_write_o=1, if_flush_o=id_flush_o=ex_flush_o=1, if_keep_o=0. Suppresses load-use.
- Load-use (not frozen, no branch): ex_memread_i=1, ex_rt_i!=0, and ex_rt_i==id_rs_i or (id_uses_rt_i and ex_rt_i==id_rt_i) -> pc_write_o=0, if_keep_o=1, id_flush_o=1.
- Normal: pc_write_o=1, all others 0.
- Branch during freeze is deferred: flushes assert in the first unfrozen cycle (RELEASE) if branch_taken_i still high.
- While rst_i low: pc_write_o=1, every keep/flush/freeze output 0, regardless of inputs.

## Timing
- Load-use stall: exactly 1 cycle per hazard; no added latency.
- Memory access: MEM_LAT frozen cycles, then 1 RELEASE cycle; total MEM_LAT+1 cycles in MEM.
- Back-to-back accesses: a new mem_req_i in the cycle after RELEASE (state RUN) starts a new wait.
- Reset mid-WAIT: state returns to RUN asynchronously; access is dropped, counters cleared.
- Stat counters update on the clock edge ending each counted cycle; saturate at all-ones, never wrap.

## Configuration
- HAZARD_STATS_EN defined: stall_cnt_o counts cycles with pc_write_o=0 (load-use and freeze); flush_cnt_o counts cycles with ex_flush_o=1.
- Undefined: counters not built; stall_cnt_o and flush_cnt_o tied to 0. Ports exist in both builds.

## Structure
- Shared package hazard_pkg: FSM state enum (RUN, WAIT, RELEASE), REG_AW default constant.
- One sub-module: hazard_mem_wait (FSM + wait counter, outputs freeze), instantiated once; hazard logic and counters stay at top.

## Test plan
- ex_memread_i=1, ex_rt_i=5, id_rs_i=5 -> one cycle pc_write_o=0, if_keep_o=1, id_flush_o=1; next cycle normal.
- ex_rt_i=0 with matching id_rs_i=0 -> no stall; id_uses_rt_i=0 with ex_rt_i=id_rt_i=7 -> no stall.
- MEM_LAT=2, mem_req_i held -> freeze_o=1 for 2 cycles, RELEASE with freeze_o=0, then RUN; MEM_LAT=1 -> 1 frozen cycle.
- branch_taken_i=1 with simultaneous load-use -> all three flushes, pc_write_o=1, no keep; branch during WAIT -> flushes only in RELEASE.
- rst_i low mid-WAIT -> immediately pc_write_o=1, freeze_o=0; after release, state RUN, counters 0.
- HAZARD_STATS_EN, CNT_W=4: 20 stall cycles -> stall_cnt_o saturates at 15; undefined build -> both 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and defaults for the pipeline hazard controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } mem_state_t;

  localparam int REG_AW_DEF = 5;

endpackage

`default_nettype wire

// File: rtl/hazard_mem_wait.sv
// ============================================================================
// Module      : hazard_mem_wait
// Description : Data-memory wait FSM; freezes the pipe for MEM_LAT cycles per
//               access, then allows one RELEASE cycle to advance the access.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_mem_wait
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  output logic freeze_o
);

  localparam int             CW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0]  C_LOAD = (MEM_LAT > 0) ? CW'(MEM_LAT - 1) : '0;
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  mem_state_t    state_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req_i && (MEM_LAT > 0)) begin
            cnt_q   <= C_LOAD;
            state_q <= (MEM_LAT == 1) ? RELEASE : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == C_ONE) state_q <= RELEASE;
        end
        RELEASE: state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // The first frozen cycle is the RUN cycle that sees the request.
  assign freeze_o = rst_i &&
                    (((state_q == RUN) && mem_req_i && (MEM_LAT > 0)) ||
                     (state_q == WAIT));

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller (freeze > branch flush > load-use).
//               Optional statistics counters enabled by HAZARD_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              mem_req_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              if_keep_o,
  output logic              if_flush_o,
  output logic              id_flush_o,
  output logic              ex_flush_o,
  output logic              freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic w_freeze;
  logic w_load_use;

  hazard_mem_wait #(
    .MEM_LAT (MEM_LAT)
  ) u_mem_wait (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mem_req_i (mem_req_i),
    .freeze_o  (w_freeze)
  );

  assign w_load_use = ex_memread_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  always_comb begin
    pc_write_o = 1'b1;
    if_keep_o  = 1'b0;
    if_flush_o = 1'b0;
    id_flush_o = 1'b0;
    ex_flush_o = 1'b0;
    freeze_o   = 1'b0;
    if (rst_i) begin
      if (w_freeze) begin
        pc_write_o = 1'b0;
        if_keep_o  = 1'b1;
        freeze_o   = 1'b1;
      end else if (branch_taken_i) begin
        if_flush_o = 1'b1;
        id_flush_o = 1'b1;
        ex_flush_o = 1'b1;
      end else if (w_load_use) begin
        pc_write_o = 1'b0;
        if_keep_o  = 1'b1;
        id_flush_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating: a stuck-at-max counter is more useful than a wrapped one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_flush_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed, table-driven bench for hazard_ctrl (MEM_LAT=2 and 1).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
  logic              uses_rt, memread, mem_req, mem_req1, branch;

  logic              pc_write, if_keep, if_flush, id_flush, ex_flush, freeze;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              pc_write1, if_keep1, if_flush1, id_flush1, ex_flush1, freeze1;
  logic [CNT_W-1:0]  stall_cnt1, flush_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_LAT(2), .REG_AW(REG_AW), .CNT_W(CNT_W)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(uses_rt), .ex_memread_i(memread), .ex_rt_i(ex_rt),
    .mem_req_i(mem_req), .branch_taken_i(branch),
    .pc_write_o(pc_write), .if_keep_o(if_keep), .if_flush_o(if_flush),
    .id_flush_o(id_flush), .ex_flush_o(ex_flush), .freeze_o(freeze),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_ctrl #(.MEM_LAT(1), .REG_AW(REG_AW), .CNT_W(CNT_W)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(uses_rt), .ex_memread_i(memread), .ex_rt_i(ex_rt),
    .mem_req_i(mem_req1), .branch_taken_i(branch),
    .pc_write_o(pc_write1), .if_keep_o(if_keep1), .if_flush_o(if_flush1),
    .id_flush_o(id_flush1), .ex_flush_o(ex_flush1), .freeze_o(freeze1),
    .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1)
  );

  // Output bundle order: {pc_write, if_keep, if_flush, id_flush, ex_flush, freeze}
  localparam logic [5:0] O_NORM   = 6'b100000;
  localparam logic [5:0] O_LU     = 6'b010100;
  localparam logic [5:0] O_BR     = 6'b101110;
  localparam logic [5:0] O_FRZ    = 6'b010001;

  typedef struct {
    string             name;
    logic [REG_AW-1:0] rs, rt, xrt;
    logic              urt, mrd, br;
    logic [5:0]        exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [5:0] outs0();
    return {pc_write, if_keep, if_flush, id_flush, ex_flush, freeze};
  endfunction

  function automatic logic [5:0] outs1();
    return {pc_write1, if_keep1, if_flush1, id_flush1, ex_flush1, freeze1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    uses_rt = 1'b0; memread = 1'b0; mem_req = 1'b0; mem_req1 = 1'b0; branch = 1'b0;
  endtask

  task automatic set_lu();
    memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"normal",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[1] = '{"lu_rs",         5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, O_LU};
    vecs[2] = '{"lu_r0",         5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, O_NORM};
    vecs[3] = '{"lu_rt_unused",  5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, O_NORM};
    vecs[4] = '{"lu_rt_used",    5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, O_LU};
    vecs[5] = '{"no_load",       5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, O_NORM};
    vecs[6] = '{"branch_lu",     5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, O_BR};
    vecs[7] = '{"branch_only",   5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, O_BR};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_outs", 32'(outs0()), 32'(O_NORM));
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    set_lu(); mem_req = 1'b1; branch = 1'b1;
    #1;
    chk("reset_forced_outs", 32'(outs0()), 32'(O_NORM));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational vectors, all in RUN (no memory request).
    foreach (vecs[i]) begin
      @(negedge clk);
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rt = vecs[i].xrt;
      uses_rt = vecs[i].urt; memread = vecs[i].mrd; branch = vecs[i].br;
      #1;
      chk(vecs[i].name, 32'(outs0()), 32'(vecs[i].exp));
    end

    // Load-use stall lasts one cycle: instruction moves on, hazard clears.
    @(negedge clk); idle_inputs(); set_lu(); #1;
    chk("lu_cycle", 32'(outs0()), 32'(O_LU));
    @(negedge clk); idle_inputs(); #1;
    chk("lu_next_normal", 32'(outs0()), 32'(O_NORM));

    // MEM_LAT=2 held request: 2 frozen, RELEASE, then a new access.
    do_reset();
    mem_req = 1'b1; set_lu(); #1;
    chk("mem_run_freeze", 32'(outs0()), 32'(O_FRZ));
    @(negedge clk); #1;
    chk("mem_wait_freeze", 32'(outs0()), 32'(O_FRZ));
    @(negedge clk); memread = 1'b0; #1;
    chk("mem_release", 32'(outs0()), 32'(O_NORM));
    @(negedge clk); #1;
    chk("mem_back_to_back", 32'(outs0()), 32'(O_FRZ));
    // Branch arriving in WAIT is held off until RELEASE.
    @(negedge clk); mem_req = 1'b0; branch = 1'b1; #1;
    chk("branch_in_wait", 32'(outs0()), 32'(O_FRZ));
    @(negedge clk); #1;
    chk("branch_in_release", 32'(outs0()), 32'(O_BR));
    @(negedge clk); branch = 1'b0; #1;
    chk("after_release_run", 32'(outs0()), 32'(O_NORM));

    // MEM_LAT=1 instance: one frozen cycle then RELEASE.
    @(negedge clk); idle_inputs(); mem_req1 = 1'b1; #1;
    chk("lat1_freeze", 32'(outs1()), 32'(O_FRZ));
    @(negedge clk); #1;
    chk("lat1_release", 32'(outs1()), 32'(O_NORM));
    @(negedge clk); #1;
    chk("lat1_restart", 32'(outs1()), 32'(O_FRZ));
    @(negedge clk); mem_req1 = 1'b0;

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk); idle_inputs(); mem_req = 1'b1;
    @(negedge clk); #1;
    chk("pre_reset_wait", 32'(outs0()), 32'(O_FRZ));
    #2; rst_n = 1'b0; #1;
    chk("reset_in_wait", 32'(outs0()), 32'(O_NORM));
    @(negedge clk); mem_req = 1'b0; rst_n = 1'b1; #1;
    chk("post_reset_run", 32'(outs0()), 32'(O_NORM));
    chk("post_reset_stall_cnt", 32'(stall_cnt), 0);
    chk("post_reset_flush_cnt", 32'(flush_cnt), 0);

    // 20 stall cycles then 2 flush cycles.
    @(negedge clk); set_lu();
    repeat (20) @(negedge clk);
    idle_inputs(); branch = 1'b1;
    repeat (2) @(negedge clk);
    branch = 1'b0; #1;
`ifdef HAZARD_STATS_EN
    chk("stall_cnt_sat", 32'(stall_cnt), 15);
    chk("flush_cnt", 32'(flush_cnt), 2);
`else
    chk("stall_cnt_off", 32'(stall_cnt), 0);
    chk("flush_cnt_off", 32'(flush_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
